mul_seq_ctrl: RTL and testbench

Sequential multiplier controller. It computes an unsigned WIDTH×WIDTH product by driving the team's 2-bit × 2-bit combinational multiplier cell (mulbit2) over every pair of operand digits, one partial product per clock. Each partial product is shifted and accumulated into a 2·WIDTH-bit register. The block sits between a requester using a start/busy/done handshake and the single shared mulbit2 instance, trading latency for area in place of a full-width array multiplier.

---
 rtl/mul_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2 mulbit2 cell.
// Optional feature macro: MULSEQ_ZERO_SKIP_EN (zero operand completes in IDLE with p=0).

module mulbit2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    assign p_o = {2'b00, a_i} * {2'b00, b_i};

endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int N  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(PW);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;

    logic [1:0]      a_dig_s;
    logic [1:0]      b_dig_s;
    logic [3:0]      pp_s;
    logic [SW-1:0]   shamt_s;
    logic [PW-1:0]   pp_shift_s;
    logic [PW-1:0]   acc_sum_s;
    logic            last_s;
    logic            go_run_s;
    logic            go_skip_s;

    // Digit select, 2x2 product, shift into place and accumulate.
    assign a_dig_s    = a_q[{i_q, 1'b0} +: 2];
    assign b_dig_s    = b_q[{j_q, 1'b0} +: 2];
    assign shamt_s    = SW'({i_q, 1'b0}) + SW'({j_q, 1'b0});
    assign pp_shift_s = {{(PW-4){1'b0}}, pp_s} << shamt_s;
    assign acc_sum_s  = acc_q + pp_shift_s;
    assign last_s     = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    mulbit2 u_mulbit2 (
        .a_i (a_dig_s),
        .b_i (b_dig_s),
        .p_o (pp_s)
    );

    // Classify a start request seen in IDLE.
    always_comb begin
        go_run_s  = 1'b0;
        go_skip_s = 1'b0;
        if (start && (state_q == ST_IDLE)) begin
`ifdef MULSEQ_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
                go_skip_s = 1'b1;
            end else begin
                go_run_s = 1'b1;
            end
`else
            go_run_s = 1'b1;
`endif
        end else begin
            go_run_s  = 1'b0;
            go_skip_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_run_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            p_q    <= p_d;
            done_q <= done_d;
            busy_q <= busy_d;
            i_q    <= i_d;
            j_q    <= j_d;
        end
    end

    // Datapath next-state: capture, accumulate, advance digit counters.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        p_d    = p_q;
        done_d = 1'b0;
        i_d    = i_q;
        j_d    = j_q;
        busy_d = (state_d == ST_RUN);
        case (state_q)
            ST_IDLE: begin
                if (go_run_s) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                end else if (go_skip_s) begin
                    p_d    = '0;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum_s;
                if (last_s) begin
                    p_d    = acc_sum_s;
                    done_d = 1'b1;
                    i_d    = '0;
                    j_d    = '0;
                end else if (j_q == LAST_IDX) begin
                    j_d = '0;
                    i_d = i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            default: begin
                acc_d = '0;
                i_d   = '0;
                j_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        busy = busy_q;
        done = done_q;
        p    = p_q;
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH=8), honouring MULSEQ_ZERO_SKIP_EN.

module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int checks   = 0;
    int failures = 0;

    mul_seq_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One start pulse; lat counts edges after the accepting edge until done is seen.
    task automatic run_mul(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] ep, input int elat, input int ebusy);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        a      = av;
        b      = bv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        if (busy) busy_n++;
        while (!done && lat < 64) begin
            tick();
            lat++;
            if (!done && busy) busy_n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
        check_eq({tag, "_p"}, 32'(p), 32'(ep));
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(ebusy));
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_done;
        int first;
        int second;
        int bad;
        logic [15:0] p1;
        logic [15:0] p2;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_p", 32'(p), 32'd0);

        run_mul("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 16, 16);

        run_mul("0d_0b", 8'h0D, 8'h0B, 16'h008F, 16, 16);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (p !== 16'h008F || done !== 1'b0) bad++;
        end
        check_eq("hold_p_idle", 32'(bad), 32'd0);

`ifdef MULSEQ_ZERO_SKIP_EN
        run_mul("zero_a", 8'h00, 8'h37, 16'h0000, 0, 0);
`else
        run_mul("zero_a", 8'h00, 8'h37, 16'h0000, 16, 16);
`endif

        // start raised again while busy must be ignored
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start  = 1'b0;
        n_done = 0;
        first  = -1;
        p1     = 16'h0000;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                n_done++;
                if (first < 0) begin
                    first = c;
                    p1    = p;
                end
            end
        end
        check_eq("busy_ign_ndone", 32'(n_done), 32'd1);
        check_eq("busy_ign_lat", 32'(first), 32'd16);
        check_eq("busy_ign_p", 32'(p1), 32'h03A8);

        // reset in the middle of a run discards it
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_p", 32'(p), 32'd0);
        run_mul("after_rst", 8'h03, 8'h07, 16'h0015, 16, 16);

        // back-to-back with start held high through the done cycle
        a     = 8'h10;
        b     = 8'h10;
        start = 1'b1;
        tick();
        a      = 8'h02;
        b      = 8'h80;
        n_done = 0;
        first  = -1;
        second = -1;
        p1     = 16'h0000;
        p2     = 16'h0000;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done) begin
                n_done++;
                if (first < 0) begin
                    first = c;
                    p1    = p;
                end else if (second < 0) begin
                    second = c;
                    p2     = p;
                    start  = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_ndone", 32'(n_done), 32'd2);
        check_eq("b2b_first_lat", 32'(first), 32'd16);
        check_eq("b2b_second_lat", 32'(second - first - 1), 32'd16);
        check_eq("b2b_p1", 32'(p1), 32'h0100);
        check_eq("b2b_p2", 32'(p2), 32'h0100);
        check_eq("b2b_idle_busy", 32'(busy), 32'd0);

        // rst together with start: nothing accepted
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h05;
        b     = 8'h05;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_start_busy", 32'(busy), 32'd0);
        check_eq("rst_start_p", 32'(p), 32'd0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check_eq("rst_start_quiet", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
